// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: hex glyph table,
// blank patterns and the scan controller state type.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low glyphs for 0..F; bit7 (dp) is kept high here and applied by the decoder.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        ScanIdle,
        ScanRun
    } scan_state_e;

    function automatic logic [MAX_DIGITS-1:0] node_off();
        return '1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder with active-low outputs.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] segment
);

    logic [7:0] glyph;

    always_comb begin
        glyph   = HEX_SEG[code];
        segment = {~dp, glyph[6:0]};
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment display scanner with frame-coherent input
// snapshots, blanking, blinking and leading-zero suppression.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned PRESCALE       = 16384,
    parameter int unsigned BLINK_DIV_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   node,
    output logic [7:0]              segment,
    output logic                    frame_start
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST     = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] NODE_OFF_ALL = node_off();
    localparam logic [NUM_DIGITS-1:0] NODE_OFF     = NODE_OFF_ALL[NUM_DIGITS-1:0];

    scan_state_e               state_q, state_d;
    logic [PRE_W-1:0]          pre_q, pre_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BLINK_DIV_BITS-1:0] frame_q, frame_d;
    logic [4*NUM_DIGITS-1:0]   sh_data_q;
    logic [NUM_DIGITS-1:0]     sh_dp_q, sh_blank_q, sh_blink_q;
    logic [NUM_DIGITS-1:0]     node_q, node_d;
    logic [7:0]                seg_q, seg_d;
    logic                      fs_q, fs_d;
    logic                      capture;

    logic                      slot_end, wrap, boundary;
    logic [NUM_DIGITS-1:0]     lz_dark;
    logic                      zero_run;
    logic                      digit_dark;
    logic [3:0]                cur_code;
    logic [7:0]                dec_seg;

    // Digits above the most significant non-zero nibble go dark; digit 0 always shows.
    always_comb begin
        lz_dark  = '0;
        zero_run = lz_suppress;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_run   = zero_run && (sh_data_q[4*i +: 4] == 4'h0);
            lz_dark[i] = zero_run;
        end
    end

    assign cur_code   = sh_data_q[{idx_q, 2'b00} +: 4];
    assign digit_dark = sh_blank_q[idx_q]
                      | (sh_blink_q[idx_q] & frame_q[BLINK_DIV_BITS-1])
                      | lz_dark[idx_q];

    seg7_decode u_decode (
        .code    (cur_code),
        .dp      (sh_dp_q[idx_q]),
        .segment (dec_seg)
    );

    assign slot_end = (state_q == ScanRun) && (pre_q == PRE_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);
    assign boundary = enable && ((state_q == ScanIdle) || wrap);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        capture = 1'b0;
        fs_d    = 1'b0;
        node_d  = NODE_OFF;
        seg_d   = SEG_OFF;
        if (!enable) begin
            state_d = ScanIdle;
            pre_d   = '0;
            idx_d   = '0;
        end else begin
            state_d = ScanRun;
            if (boundary) begin
                pre_d   = '0;
                idx_d   = '0;
                frame_d = frame_q + 1'b1;
                capture = 1'b1;
                fs_d    = 1'b1;
            end else if (slot_end) begin
                pre_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
            // Shadows are stale until the first snapshot lands, so stay dark while idle.
            if ((state_q == ScanRun) && !digit_dark) begin
                node_d = ~(NUM_DIGITS'(1) << idx_q);
                seg_d  = dec_seg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ScanIdle;
            pre_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            sh_blank_q <= '0;
            sh_blink_q <= '0;
            node_q     <= NODE_OFF;
            seg_q      <= SEG_OFF;
            fs_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            node_q  <= node_d;
            seg_q   <= seg_d;
            fs_q    <= fs_d;
            if (capture) begin
                sh_data_q  <= digit_data;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank_in;
                sh_blink_q <= blink_in;
            end
        end
    end

    assign node        = node_q;
    assign segment     = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: per-frame expectations are queued at each
// snapshot and popped against the scanned outputs.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BB = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [15:0] digit_data = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  blink_in = 4'h0;
    logic [3:0]  node;
    logic [7:0]  segment;
    logic        frame_start;

    int compared = 0;
    int mismatched = 0;
    int m_frames = 0;

    logic [7:0] hex_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [3:0] node;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];

    seg_scan_display #(
        .NUM_DIGITS     (ND),
        .PRESCALE       (PS),
        .BLINK_DIV_BITS (BB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digit_data  (digit_data),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .lz_suppress (lz_suppress),
        .node        (node),
        .segment     (segment),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (frame_start === 1'b1) m_frames++;
    endtask

    task automatic check_dark(input string tag);
        check({tag, " node"}, {4'h0, node}, 8'h0F);
        check({tag, " seg"}, segment, 8'hFF);
        check({tag, " fs"}, {7'h0, frame_start}, 8'h00);
    endtask

    // now=1 accepts a pulse already visible at the current negedge.
    task automatic wait_fs(input bit now);
        int n = 0;
        if (!now || frame_start !== 1'b1) begin
            tick();
            while (frame_start !== 1'b1 && n < 64) begin
                tick();
                n++;
            end
        end
        check("frame_start seen", {7'h0, frame_start}, 8'h01);
    endtask

    task automatic check_frame(input bit now, input int change_at, input logic [15:0] new_data);
        logic [15:0] sd;
        logic [3:0]  sdp, sbl, sbk;
        logic        ph;
        int          hi;
        bit          dark;
        exp_t        e;
        exp_t        got;
        wait_fs(now);
        sd  = digit_data;
        sdp = dp_in;
        sbl = blank_in;
        sbk = blink_in;
        ph  = m_frames[0];
        hi  = 0;
        for (int i = 0; i < ND; i++) if (sd[4*i +: 4] != 4'h0) hi = i;
        for (int i = 0; i < ND; i++) begin
            dark = sbl[i] || (sbk[i] && ph) || (lz_suppress && i > hi);
            e.node = dark ? 4'hF : ~(4'b0001 << i);
            e.seg  = dark ? 8'hFF : {~sdp[i], hex_tbl[sd[4*i +: 4]][6:0]};
            repeat (PS) sb.push_back(e);
        end
        for (int k = 0; k < ND * PS; k++) begin
            tick();
            got = sb.pop_front();
            check($sformatf("node d%0d c%0d", k / PS, k % PS), {4'h0, node}, {4'h0, got.node});
            check($sformatf("seg d%0d c%0d", k / PS, k % PS), segment, got.seg);
            if (k < ND * PS - 1) check("fs quiet", {7'h0, frame_start}, 8'h00);
            if (k == change_at) digit_data = new_data;
        end
    endtask

    initial begin
        repeat (2) tick();
        check_dark("reset");

        rst_n      = 1'b1;
        enable     = 1'b1;
        digit_data = 16'h12AF;
        m_frames   = 0;
        check_frame(1'b0, -1, 16'h0);
        check_frame(1'b1, -1, 16'h0);

        // Mid-frame data change must not tear the current frame.
        check_frame(1'b1, 5, 16'h3456);
        check_frame(1'b1, -1, 16'h0);

        lz_suppress = 1'b1;
        digit_data  = 16'h0005;
        check_frame(1'b0, -1, 16'h0);
        digit_data = 16'h0000;
        check_frame(1'b0, -1, 16'h0);
        lz_suppress = 1'b0;

        digit_data = 16'h12AF;
        blink_in   = 4'b0001;
        dp_in      = 4'b0100;
        check_frame(1'b0, -1, 16'h0);
        check_frame(1'b1, -1, 16'h0);
        check_frame(1'b1, -1, 16'h0);

        blink_in = 4'b0000;
        dp_in    = 4'b0000;
        repeat (6) tick();
        enable = 1'b0;
        repeat (10) begin
            tick();
            check_dark("disabled");
        end
        enable = 1'b1;
        check_frame(1'b0, -1, 16'h0);

        // Drop enable right before the wrap edge: no pulse may escape.
        repeat (ND * PS - 1) tick();
        enable = 1'b0;
        tick();
        check_dark("enable wins");
        repeat (3) tick();
        enable = 1'b1;
        check_frame(1'b0, -1, 16'h0);

        repeat (9) tick();
        check("digit2 lit before reset", {4'h0, node}, 8'h0B);
        #2 rst_n = 1'b0;
        m_frames = 0;
        #1 check_dark("async reset");
        tick();
        tick();
        rst_n = 1'b1;
        check_frame(1'b0, -1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 2..8).
REQ-002 SHALL have parameter PRESCALE, default 16384, meaning clk cycles per digit slot (legal minimum 2).
REQ-003 SHALL have parameter BLINK_DIV_BITS, default 6, meaning the width of the frame counter; its MSB is the blink phase.
REQ-004 SHALL have port clk, input, width 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, width 1: 1 = scanning; 0 = display dark and scan idle.
REQ-007 SHALL have port digit_data, input, width 4*NUM_DIGITS: hex codes, nibble i feeds digit i (digit 0 = least significant).
REQ-008 SHALL have port dp_in, input, width NUM_DIGITS: 1 = decimal point lit on digit i.
REQ-009 SHALL have port blank_in, input, width NUM_DIGITS: 1 = digit i forced dark.
REQ-010 SHALL have port blink_in, input, width NUM_DIGITS: 1 = digit i dark while the blink phase is 1.
REQ-011 SHALL have port lz_suppress, input, width 1: 1 = leading-zero suppression on.
REQ-012 SHALL have port node, output, width NUM_DIGITS: active-low digit selects.
REQ-013 SHALL have port segment, output, width 8: active-low segments; bit7 = dp, bits 6..0 = g..a.
REQ-014 SHALL have port frame_start, output, width 1: one-cycle pulse marking each input snapshot.

Function
REQ-015 SHALL run a prescaler from 0 to PRESCALE-1; at terminal count the digit index SHALL advance 0,1,..,NUM_DIGITS-1 and then wrap to 0.
REQ-016 SHALL capture digit_data, dp_in, blank_in and blink_in into shadow registers at a frame boundary, and SHALL pulse frame_start on that same edge.
REQ-017 A frame boundary SHALL occur on the index wrap to 0, on the first enabled edge after reset, and on the first edge after enable rises.
REQ-018 SHALL ignore input changes made inside a frame until the next boundary, so that there is no tearing.
REQ-019 SHALL register node and segment together from shadow[index], one cycle after each index change, and both SHALL always change on the same edge.
REQ-020 SHALL hold each digit for exactly PRESCALE cycles, with exactly one node bit low when the digit is lit.
REQ-021 Hex decode SHALL be, for 0..F, segment[6:0] = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex, bit7 set).
REQ-022 Segment bit7 SHALL be 0 only when dp of that digit is 1 and the digit is not dark.
REQ-023 With lz_suppress=1, zero nibbles contiguous from digit NUM_DIGITS-1 downward SHALL be dark; digit 0 SHALL never be suppressed.
REQ-024 SHALL increment the frame counter on every frame boundary and wrap it modulo 2^BLINK_DIV_BITS.
REQ-025 A dark digit (blank, blink phase, or suppression) SHALL drive node all-ones and segment 8'hFF for its full slot.
REQ-026 With enable=0, on the next edge node SHALL be all-ones, segment 8'hFF, prescaler 0, index 0 and frame counter held, with no frame_start pulse.
REQ-027 When a boundary coincides with enable falling, enable SHALL win.

Reset
REQ-028 rst_n low SHALL asynchronously force node all-ones, segment 8'hFF, frame_start 0, prescaler 0, index 0, frame counter 0 and shadows 0.
REQ-029 Reset asserted mid-slot SHALL darken the display immediately; after release, scanning SHALL restart at digit 0 with a fresh snapshot.

Structure
REQ-030 Package seg_pkg SHALL hold the 16-entry hex-to-segment table, SEG_OFF = 8'hFF and the node-off constant function.
REQ-031 SHALL instantiate one combinational sub-module, seg7_decode (4-bit code and dp in, 8-bit active-low segment out).

Verification (NUM_DIGITS=4, PRESCALE=4, BLINK_DIV_BITS=1)
REQ-032 digit_data=16'h12AF, masks 0, enable=1 -> node 1110,1101,1011,0111, each held 4 cycles, with segment 8E,88,A4,F9, repeating.
REQ-033 digit_data changed to 16'h3456 during digit 1 -> remaining digits keep 12AF values; 3456 appears only after the next frame_start.
REQ-034 lz_suppress=1, data 16'h0005 -> digits 3..1 dark (node 1111, segment FF) and digit 0 = 92; with data 16'h0000 -> digit 0 = C0.
REQ-035 blink_in=4'b0001, dp_in=4'b0100 -> digit 0 lit and dark in alternate frames; digit 2 segment has bit7=0 every frame.
REQ-036 rst_n low during digit 2 slot -> node 1111 and segment FF without a clock edge; after release frame_start pulses and digit 0 is shown first.
REQ-037 enable low for 10 cycles mid-frame -> outputs dark and no frame_start; when enable rises -> snapshot taken and digit 0 is shown first.
